// File: rtl/dot_matrix_display_scheduler_pkg.sv
// Shared types and constants for the Pong dot-matrix display scheduler.
// Also holds the digit saturation helper.
package pong_display_pkg;

    typedef enum logic [1:0] {
        SHOW_A     = 2'd0,
        SHOW_B     = 2'd1,
        GOAL_FLASH = 2'd2,
        GAME_OVER  = 2'd3
    } disp_state_e;

    localparam logic [3:0] MAX_DIGIT = 4'd9;
    localparam logic       SIDE_A    = 1'b0;
    localparam logic       SIDE_B    = 1'b1;

    // Scores above 9 cannot be drawn as a single glyph, so they pin at 9.
    function automatic logic [3:0] sat_digit(input logic [3:0] x);
        return (x > MAX_DIGIT) ? MAX_DIGIT : x;
    endfunction

endpackage

// File: rtl/dot_matrix_display_scheduler_if.sv
// Bundle between the game-logic/score block (master) and the display scheduler (slave).
// Carries score/event inputs and the digit/blank/scan outputs.
interface dot_matrix_display_scheduler_if;

    logic [3:0] score_a;
    logic [3:0] score_b;
    logic       goal_a;
    logic       goal_b;
    logic       game_over;
    logic       winner;
    logic [3:0] ascii_code;
    logic       blank;
    logic       side;
    logic       scan_en;
    logic       busy;

    modport master (
        output score_a, score_b, goal_a, goal_b, game_over, winner,
        input  ascii_code, blank, side, scan_en, busy
    );

    modport slave (
        input  score_a, score_b, goal_a, goal_b, game_over, winner,
        output ascii_code, blank, side, scan_en, busy
    );

endinterface

// File: rtl/dot_matrix_display_scheduler_tick_gen.sv
// Modulo-DIV counter that emits a one-cycle pulse on the cycle it wraps.
// A synchronous clear restarts the count so the next pulse is a full DIV cycles away.
module display_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pulse
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse = (cnt_q == LAST);

endmodule

// File: rtl/dot_matrix_display_scheduler.sv
// Time-shares the 8x8 dot-matrix between score A, score B, goal flash and game-over banner.
// All outputs are registered from the current state, so they trail a state change by one clk.
module dot_matrix_display_scheduler
    import pong_display_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned SCAN_DIV    = 5000,
    parameter int unsigned DWELL_TICKS = 1000,
    parameter int unsigned BLINK_TICKS = 250,
    parameter int unsigned BLINK_COUNT = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    dot_matrix_display_scheduler_if.slave bus
);

    localparam int unsigned DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int unsigned BTICK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned BHALF_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
    localparam logic [BTICK_W-1:0] BTICK_LAST = BTICK_W'(BLINK_TICKS - 1);
    localparam logic [BHALF_W-1:0] BHALF_LAST = BHALF_W'(BLINK_COUNT - 1);

    logic tick;
    logic scan_pulse;
    logic tick_clr;
    logic enter;
    logic goal_any;
    logic goal_side;

    disp_state_e        state_q,  state_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic [BTICK_W-1:0] btick_q,  btick_d;
    logic [BHALF_W-1:0] bhalf_q,  bhalf_d;
    logic               scorer_q, scorer_d;
    logic [3:0]         ascii_code_q, ascii_code_d;
    logic               blank_q,   blank_d;
    logic               side_q,    side_d;
    logic               scan_en_q, scan_en_d;
    logic               busy_q,    busy_d;

    // The base tick restarts on every goal so each flash half-period is exactly BLINK_TICKS ticks.
    display_tick_gen #(.DIV(TICK_DIV)) u_base_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (tick_clr),
        .pulse (tick)
    );

    display_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .pulse (scan_pulse)
    );

    assign goal_any  = bus.goal_a | bus.goal_b;
    assign goal_side = bus.goal_a ? SIDE_A : SIDE_B;

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        btick_d  = btick_q;
        bhalf_d  = bhalf_q;
        scorer_d = scorer_q;
        tick_clr = 1'b0;
        enter    = 1'b0;

        if (bus.game_over) begin
            if (state_q != GAME_OVER) begin
                state_d = GAME_OVER;
                enter   = 1'b1;
            end
        end else if (state_q == GAME_OVER) begin
            state_d = SHOW_A;
            enter   = 1'b1;
        end else if (goal_any) begin
            // Also covers a goal during GOAL_FLASH: the flash restarts for the new scorer.
            state_d  = GOAL_FLASH;
            scorer_d = goal_side;
            tick_clr = 1'b1;
            enter    = 1'b1;
        end else begin
            case (state_q)
                SHOW_A, SHOW_B: begin
                    if (tick) begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = (state_q == SHOW_A) ? SHOW_B : SHOW_A;
                            enter   = 1'b1;
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                end
                GOAL_FLASH: begin
                    if (tick) begin
                        if (btick_q == BTICK_LAST) begin
                            btick_d = '0;
                            if (bhalf_q == BHALF_LAST) begin
                                state_d = (scorer_q == SIDE_A) ? SHOW_B : SHOW_A;
                                enter   = 1'b1;
                            end else begin
                                bhalf_d = bhalf_q + BHALF_W'(1);
                            end
                        end else begin
                            btick_d = btick_q + BTICK_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        if (enter) begin
            dwell_d = '0;
            btick_d = '0;
            bhalf_d = '0;
        end
    end

    always_comb begin
        ascii_code_d = sat_digit(bus.score_a);
        side_d       = SIDE_A;
        blank_d      = 1'b0;
        busy_d       = 1'b0;
        scan_en_d    = scan_pulse;
        case (state_q)
            SHOW_B: begin
                side_d       = SIDE_B;
                ascii_code_d = sat_digit(bus.score_b);
            end
            GOAL_FLASH: begin
                side_d       = scorer_q;
                ascii_code_d = sat_digit((scorer_q == SIDE_B) ? bus.score_b : bus.score_a);
                blank_d      = bhalf_q[0];
                busy_d       = 1'b1;
            end
            GAME_OVER: begin
                side_d       = bus.winner;
                ascii_code_d = sat_digit((bus.winner == SIDE_B) ? bus.score_b : bus.score_a);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SHOW_A;
            dwell_q      <= '0;
            btick_q      <= '0;
            bhalf_q      <= '0;
            scorer_q     <= SIDE_A;
            ascii_code_q <= '0;
            blank_q      <= 1'b1;
            side_q       <= SIDE_A;
            scan_en_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            btick_q      <= btick_d;
            bhalf_q      <= bhalf_d;
            scorer_q     <= scorer_d;
            ascii_code_q <= ascii_code_d;
            blank_q      <= blank_d;
            side_q       <= side_d;
            scan_en_q    <= scan_en_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ascii_code = ascii_code_q;
    assign bus.blank      = blank_q;
    assign bus.side       = side_q;
    assign bus.scan_en    = scan_en_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dot_matrix_display_scheduler.sv
// Bench for dot_matrix_display_scheduler: vector table, scenario sequences and random traffic,
// all checked against an edge-count reference model of the display rules.
module tb_dot_matrix_display_scheduler;

    localparam int TD    = 4;
    localparam int SD    = 3;
    localparam int DWT   = 3;
    localparam int BT    = 2;
    localparam int BC    = 4;
    localparam int HALF  = BT * TD;
    localparam int FLASH = HALF * BC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_matrix_display_scheduler_if bus();

    dot_matrix_display_scheduler #(
        .TICK_DIV    (TD),
        .SCAN_DIV    (SD),
        .DWELL_TICKS (DWT),
        .BLINK_TICKS (BT),
        .BLINK_COUNT (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: mode 0 = showing A, 1 = showing B, 2 = goal flash, 3 = game over.
    int m_mode = 0, m_entry = 0, m_origin = 0, m_scan_origin = 0, m_scorer = 0;
    int e_ascii = 0, e_blank = 1, e_side = 0, e_scan = 0, e_busy = 0;

    typedef struct {
        int r, sa, sb, ga, gb, go, w;
        int ea, eb, es, esc, ebusy;
    } vec_t;
    vec_t tbl[15];

    function automatic int satf(input int x);
        return (x > 9) ? 9 : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic set_in(input int sa, input int sb, input int ga, input int gb,
                          input int go, input int w);
        bus.score_a   = 4'(sa);
        bus.score_b   = 4'(sb);
        bus.goal_a    = 1'(ga);
        bus.goal_b    = 1'(gb);
        bus.game_over = 1'(go);
        bus.winner    = 1'(w);
    endtask

    // Evaluated at each rising edge with the inputs the DUT samples there.
    task automatic model_edge();
        int sa, sb, w;
        sa = int'(bus.score_a);
        sb = int'(bus.score_b);
        w  = int'(bus.winner);
        if (rst) begin
            m_mode = 0; m_entry = edge_n; m_origin = edge_n; m_scan_origin = edge_n; m_scorer = 0;
            e_ascii = 0; e_blank = 1; e_side = 0; e_scan = 0; e_busy = 0;
            return;
        end
        e_scan = ((edge_n - m_scan_origin) % SD == 0) ? 1 : 0;
        e_blank = 0;
        e_busy  = 0;
        case (m_mode)
            0: begin e_side = 0; e_ascii = satf(sa); end
            1: begin e_side = 1; e_ascii = satf(sb); end
            2: begin
                e_side  = m_scorer;
                e_ascii = satf(m_scorer == 1 ? sb : sa);
                e_blank = ((edge_n - 1 - m_entry) / HALF) % 2;
                e_busy  = 1;
            end
            default: begin e_side = w; e_ascii = satf(w == 1 ? sb : sa); end
        endcase
        if (bus.game_over) begin
            if (m_mode != 3) begin m_mode = 3; m_entry = edge_n; end
        end else if (m_mode == 3) begin
            m_mode = 0; m_entry = edge_n;
        end else if (bus.goal_a || bus.goal_b) begin
            m_mode = 2; m_scorer = bus.goal_a ? 0 : 1; m_entry = edge_n; m_origin = edge_n;
        end else if (m_mode < 2) begin
            if ((edge_n - m_origin) / TD - (m_entry - m_origin) / TD == DWT) begin
                m_mode = 1 - m_mode; m_entry = edge_n;
            end
        end else if (edge_n - m_entry == FLASH) begin
            m_mode = (m_scorer == 1) ? 0 : 1; m_entry = edge_n;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        chk("model_ascii", int'(bus.ascii_code), e_ascii);
        chk("model_blank", int'(bus.blank), e_blank);
        chk("model_side", int'(bus.side), e_side);
        chk("model_scan", int'(bus.scan_en), e_scan);
        chk("model_busy", int'(bus.busy), e_busy);
    endtask

    task automatic alternation_check(input string tag);
        for (int i = 1; i <= 48; i++) begin
            step();
            chk({tag, "_side"}, int'(bus.side), ((i - 1) / 12) % 2);
            chk({tag, "_ascii"}, int'(bus.ascii_code), (((i - 1) / 12) % 2 == 1) ? 7 : 3);
            chk({tag, "_scan"}, int'(bus.scan_en), (i % 3 == 0) ? 1 : 0);
        end
    endtask

    initial begin
        int found;
        int busy_len;
        int go_lvl;

        set_in(3, 7, 0, 0, 0, 0);

        //          r  sa  sb ga gb go  w   ea eb es esc busy
        tbl[0]  = '{1,  3,  7, 0, 0, 0, 0,   0, 1, 0, 0, 0};
        tbl[1]  = '{1,  3,  7, 0, 0, 0, 0,   0, 1, 0, 0, 0};
        tbl[2]  = '{0,  3,  7, 0, 0, 0, 0,   3, 0, 0, 0, 0};
        tbl[3]  = '{0, 12,  7, 0, 0, 0, 0,   9, 0, 0, 0, 0};
        tbl[4]  = '{0,  3,  7, 1, 1, 0, 0,   3, 0, 0, 1, 0};
        tbl[5]  = '{0,  3,  7, 0, 0, 0, 0,   3, 0, 0, 0, 1};
        tbl[6]  = '{0,  3,  7, 0, 1, 0, 0,   3, 0, 0, 0, 1};
        tbl[7]  = '{0,  3, 11, 0, 0, 0, 0,   9, 0, 1, 1, 1};
        tbl[8]  = '{0,  3,  7, 0, 0, 1, 1,   7, 0, 1, 0, 1};
        tbl[9]  = '{0,  3,  7, 0, 0, 1, 1,   7, 0, 1, 0, 0};
        tbl[10] = '{0,  3,  7, 0, 1, 1, 0,   3, 0, 0, 1, 0};
        tbl[11] = '{0,  3,  7, 0, 0, 0, 0,   3, 0, 0, 0, 0};
        tbl[12] = '{0,  3,  7, 0, 0, 0, 0,   3, 0, 0, 0, 0};
        tbl[13] = '{1,  3,  7, 0, 0, 0, 0,   0, 1, 0, 0, 0};
        tbl[14] = '{0,  3,  7, 0, 0, 0, 0,   3, 0, 0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            rst = 1'(tbl[i].r);
            set_in(tbl[i].sa, tbl[i].sb, tbl[i].ga, tbl[i].gb, tbl[i].go, tbl[i].w);
            step();
            chk($sformatf("tbl%0d_ascii", i), int'(bus.ascii_code), tbl[i].ea);
            chk($sformatf("tbl%0d_blank", i), int'(bus.blank), tbl[i].eb);
            chk($sformatf("tbl%0d_side", i), int'(bus.side), tbl[i].es);
            chk($sformatf("tbl%0d_scan", i), int'(bus.scan_en), tbl[i].esc);
            chk($sformatf("tbl%0d_busy", i), int'(bus.busy), tbl[i].ebusy);
        end

        // Reset then free alternation between A and B.
        set_in(3, 7, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        alternation_check("alt");

        // Goal B flash: four 8-clk halves, then back to showing A.
        set_in(3, 5, 0, 1, 0, 0);
        step();
        bus.goal_b = 1'b0;
        for (int k = 0; k < FLASH; k++) begin
            step();
            chk("flash_busy", int'(bus.busy), 1);
            chk("flash_side", int'(bus.side), 1);
            chk("flash_ascii", int'(bus.ascii_code), 5);
            chk("flash_blank", int'(bus.blank), (k / HALF) % 2);
        end
        step();
        chk("flash_exit_busy", int'(bus.busy), 0);
        chk("flash_exit_side", int'(bus.side), 0);
        chk("flash_exit_ascii", int'(bus.ascii_code), 3);

        // Simultaneous goals favour A; a later goal B restarts a full flash.
        set_in(3, 7, 1, 1, 0, 0);
        step();
        set_in(3, 7, 0, 0, 0, 0);
        step();
        chk("dual_goal_side", int'(bus.side), 0);
        chk("dual_goal_busy", int'(bus.busy), 1);
        step(); step(); step();
        bus.goal_b = 1'b1;
        step();
        bus.goal_b = 1'b0;
        step();
        chk("restart_side", int'(bus.side), 1);
        chk("restart_blank", int'(bus.blank), 0);
        busy_len = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            busy_len++;
            step();
        end
        chk("restart_len", busy_len, FLASH);

        // Saturation, then game over arriving mid-flash.
        bus.score_a = 4'd12;
        step();
        chk("sat_ascii", int'(bus.ascii_code), 9);
        set_in(3, 7, 1, 0, 0, 0);
        step();
        bus.goal_a = 1'b0;
        step(); step(); step();
        set_in(3, 7, 0, 0, 1, 1);
        step();
        step();
        chk("go_busy", int'(bus.busy), 0);
        chk("go_blank", int'(bus.blank), 0);
        chk("go_side", int'(bus.side), 1);
        for (int i = 0; i < 10; i++) begin
            bus.goal_a = (i == 4) ? 1'b1 : 1'b0;
            step();
            chk("go_hold_side", int'(bus.side), 1);
            chk("go_hold_ascii", int'(bus.ascii_code), 7);
            chk("go_hold_busy", int'(bus.busy), 0);
        end
        set_in(3, 7, 0, 0, 0, 0);
        step();
        step();
        chk("go_exit_side", int'(bus.side), 0);
        chk("go_exit_ascii", int'(bus.ascii_code), 3);

        // Reset while the flash is dark.
        bus.goal_a = 1'b1;
        step();
        bus.goal_a = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (bus.blank) found = 1;
        end
        chk("wait_blank", found, 1);
        rst = 1'b1;
        step();
        chk("midrst_ascii", int'(bus.ascii_code), 0);
        chk("midrst_blank", int'(bus.blank), 1);
        chk("midrst_side", int'(bus.side), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_scan", int'(bus.scan_en), 0);
        rst = 1'b0;
        alternation_check("midrst_alt");

        // Random traffic against the model.
        go_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 199) == 0) go_lvl = 1 - go_lvl;
            if ($urandom_range(0, 15) == 0) bus.score_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.score_b = 4'($urandom_range(0, 15));
            bus.goal_a    = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
            bus.goal_b    = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
            bus.game_over = 1'(go_lvl);
            if ($urandom_range(0, 31) == 0) bus.winner = 1'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
